// File: rtl/amif_arbiter_pkg.sv
// Shared types and constants for the memory-port round-robin arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package amif_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int          DEFAULT_TIMEOUT = 1024;
    localparam logic [31:0] DEADBEEF        = 32'hDEADBEEF;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/amif_arbiter_if.sv
// Bundle of requester-side and downstream-side signals of the arbiter.
// Latency: none (wiring only).
// Backpressure: requesters hold strobe/addr/data until their req_done bit pulses.
//
// slave  : arbiter view (requests and ds_load/ds_done in, everything else out)
// master : environment view (requesters + downstream controller)
interface amif_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 32
);

    logic [NREQ-1:0]    req_read;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_store;
    logic [DW-1:0]      req_load;
    logic [NREQ-1:0]    req_done;
    logic               req_err;
    logic               ds_read;
    logic               ds_write;
    logic [AW-1:0]      ds_addr;
    logic [DW-1:0]      ds_store;
    logic [DW-1:0]      ds_load;
    logic               ds_done;
    logic [NREQ-1:0]    grant;

    modport slave (
        input  req_read, req_write, req_addr, req_store, ds_load, ds_done,
        output req_load, req_done, req_err, ds_read, ds_write, ds_addr, ds_store, grant
    );

    modport master (
        output req_read, req_write, req_addr, req_store, ds_load, ds_done,
        input  req_load, req_done, req_err, ds_read, ds_write, ds_addr, ds_store, grant
    );

endinterface

// File: rtl/amif_arbiter_rr_pick.sv
// Combinational round-robin picker: first active index at or after i_ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; o_onehot is all zero when nothing is active.
//
// i_active : per-requester active vector
// i_ptr    : index with highest priority this round (0..NREQ-1)
// o_onehot : one-hot winner
// o_idx    : binary winner index (0 when nothing is active)
module rr_pick
    import amif_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_active,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx
);

    logic w_found;
    int   w_j;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Candidate k positions past the pointer, wrapped back into range.
            w_j = int'(i_ptr) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (!w_found && i_active[w_j]) begin
                w_found       = 1'b1;
                o_onehot[w_j] = 1'b1;
                o_idx         = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/amif_arbiter.sv
// Round-robin arbiter sharing one memory-controller port among NREQ requesters.
// Latency: ds strobes 1 cycle after a request is seen in IDLE; req_done same cycle as ds_done.
// Backpressure: one transaction at a time, grant held until ds_done; others wait with strobes held.
//
// Ports: clk, rst (synchronous, active high), bus (amif_arbiter_if.slave) carrying
// req_read/req_write/req_addr/req_store in, req_load/req_done/req_err out,
// ds_read/ds_write/ds_addr/ds_store out, ds_load/ds_done in, grant out.
// Optional build macro AMIF_ARB_TIMEOUT_EN: abort a transaction after TIMEOUT BUSY
// cycles without ds_done, answering with req_err=1 and the DEADBEEF word.
module amif_arbiter
    import amif_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    amif_arbiter_if.slave bus
);

    localparam int            IW       = idx_width(NREQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    arb_state_t      r_state,    w_state_nxt;
    logic [NREQ-1:0] r_grant,    w_grant_nxt;
    logic [IW-1:0]   r_idx,      w_idx_nxt;
    logic [IW-1:0]   r_ptr,      w_ptr_nxt;
    logic            r_ds_read,  w_ds_read_nxt;
    logic            r_ds_write, w_ds_write_nxt;
    logic [AW-1:0]   r_ds_addr,  w_ds_addr_nxt;
    logic [DW-1:0]   r_ds_store, w_ds_store_nxt;

    logic [NREQ-1:0] w_active;
    logic [NREQ-1:0] w_win_oh;
    logic [IW-1:0]   w_win_idx;
    logic            w_win_rd;
    logic            w_win_wr;
    logic [AW-1:0]   w_win_addr;
    logic [DW-1:0]   w_win_store;
    logic            w_timeout;
    logic            w_fin;
    logic            w_fin_ok;
    logic            w_fin_to;

    assign w_active = bus.req_read | bus.req_write;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_active (w_active),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx)
    );

    // Mux the winner's request fields; a set write strobe masks the read strobe.
    always_comb begin
        w_win_rd    = 1'b0;
        w_win_wr    = 1'b0;
        w_win_addr  = '0;
        w_win_store = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_oh[i]) begin
                w_win_wr    = bus.req_write[i];
                w_win_rd    = bus.req_read[i] & ~bus.req_write[i];
                w_win_addr  = bus.req_addr[i*AW +: AW];
                w_win_store = bus.req_store[i*DW +: DW];
            end
        end
    end

`ifdef AMIF_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    // A ds_done in the timeout cycle takes precedence over the abort.
    assign w_timeout = (r_state == BUSY) && !bus.ds_done && (r_cnt == CW'(TIMEOUT));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_fin = ((r_state == BUSY) && bus.ds_done) || w_timeout;

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_idx_nxt      = r_idx;
        w_ptr_nxt      = r_ptr;
        w_ds_read_nxt  = r_ds_read;
        w_ds_write_nxt = r_ds_write;
        w_ds_addr_nxt  = r_ds_addr;
        w_ds_store_nxt = r_ds_store;
`ifdef AMIF_ARB_TIMEOUT_EN
        w_cnt_nxt      = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (|w_active) begin
                    w_state_nxt    = BUSY;
                    w_grant_nxt    = w_win_oh;
                    w_idx_nxt      = w_win_idx;
                    w_ds_read_nxt  = w_win_rd;
                    w_ds_write_nxt = w_win_wr;
                    w_ds_addr_nxt  = w_win_addr;
                    w_ds_store_nxt = w_win_store;
`ifdef AMIF_ARB_TIMEOUT_EN
                    w_cnt_nxt      = '0;
`endif
                end
            end
            BUSY: begin
                if (w_fin) begin
                    w_state_nxt    = IDLE;
                    w_grant_nxt    = '0;
                    w_ds_read_nxt  = 1'b0;
                    w_ds_write_nxt = 1'b0;
                    w_ds_addr_nxt  = '0;
                    w_ds_store_nxt = '0;
                    w_ptr_nxt      = (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
                end
`ifdef AMIF_ARB_TIMEOUT_EN
                else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_idx      <= '0;
            r_ptr      <= '0;
            r_ds_read  <= 1'b0;
            r_ds_write <= 1'b0;
            r_ds_addr  <= '0;
            r_ds_store <= '0;
`ifdef AMIF_ARB_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_idx      <= w_idx_nxt;
            r_ptr      <= w_ptr_nxt;
            r_ds_read  <= w_ds_read_nxt;
            r_ds_write <= w_ds_write_nxt;
            r_ds_addr  <= w_ds_addr_nxt;
            r_ds_store <= w_ds_store_nxt;
`ifdef AMIF_ARB_TIMEOUT_EN
            r_cnt      <= w_cnt_nxt;
`endif
        end
    end

    // Completion is combinational from ds_done; a reset in the same cycle abandons it.
    assign w_fin_ok = (r_state == BUSY) && bus.ds_done && !rst;
    assign w_fin_to = w_timeout && !rst;

    assign bus.req_done = (w_fin_ok || w_fin_to) ? r_grant : '0;
    assign bus.req_load = w_fin_ok ? bus.ds_load : (w_fin_to ? DW'(DEADBEEF) : '0);
    assign bus.req_err  = w_fin_to;
    assign bus.ds_read  = r_ds_read;
    assign bus.ds_write = r_ds_write;
    assign bus.ds_addr  = r_ds_addr;
    assign bus.ds_store = r_ds_store;
    assign bus.grant    = r_grant;

endmodule
